stream_mux2: RTL

- Two-input, one-output registered stream multiplexer with valid/ready handshakes.
- It is the merge end of the 1-to-2 demux path: the two branches `a` and `b` are recombined into one output stream.
- A round-robin arbiter picks the source each beat, and a single output register holds the beat.
- `out_sel` tags every output beat with its source, so a downstream demux can route responses back.

---
 rtl/stream_mux_pkg.sv | 11 +
 rtl/rr_arbiter2.sv | 62 ++++++
 rtl/stream_mux2.sv | 78 +++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types and constants for the two-input stream merge
package stream_mux_pkg;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester arbiter, round-robin or fixed priority (STREAM_MUX_FIXED_PRIO_EN)
module rr_arbiter2
    import stream_mux_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,       // [0] = a, [1] = b
    input  logic       advance,   // the current grant was consumed this cycle
    output logic       gnt_valid,
    output grant_t     gnt
);

    assign gnt_valid = |req;

`ifdef STREAM_MUX_FIXED_PRIO_EN

    // a always wins; b only gets through when a is idle
    always_comb begin
        gnt = GRANT_A;
        if (!req[0] && req[1]) begin
            gnt = GRANT_B;
        end
    end

    logic unused_fixed_prio;
    assign unused_fixed_prio = ^{clk, rst_n, advance};

`else

    grant_t last_grant_q;
    grant_t last_grant_d;

    // on a tie the requester that did not win last time is granted
    always_comb begin
        gnt = GRANT_A;
        case (req)
            2'b11:   gnt = (last_grant_q == GRANT_A) ? GRANT_B : GRANT_A;
            2'b10:   gnt = GRANT_B;
            default: gnt = GRANT_A;
        endcase
    end

    // history only moves when a beat is actually taken
    always_comb begin
        last_grant_d = last_grant_q;
        if (advance && gnt_valid) begin
            last_grant_d = gnt;
        end
    end

    // reset to b so that a wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

`endif

endmodule

// File: rtl/stream_mux2.sv
// rtl/stream_mux2.sv - registered 2:1 stream merge with source tag; STREAM_MUX_FIXED_PRIO_EN selects fixed priority
module stream_mux2
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    grant_t           out_sel_q,   out_sel_d;

    logic   gnt_valid;
    grant_t gnt;
    logic   can_load;
    logic   accept;

    // the slot can take a beat when empty or when its beat leaves this cycle
    assign can_load = !out_valid_q || out_ready;
    // readies are held low while reset is asserted
    assign accept   = rst_n && can_load && gnt_valid;

    assign a_ready  = accept && (gnt == GRANT_A);
    assign b_ready  = accept && (gnt == GRANT_B);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({b_valid, a_valid}),
        .advance   (accept),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    // load on accept, empty on a drain with nothing behind it, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = (gnt == GRANT_B) ? b_data : a_data;
            out_sel_d   = gnt;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // single output register; reset discards any buffered beat at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= GRANT_A;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
